// File: rtl/writeback_regfile_pkg.sv
// Shared architectural constants for the writeback, execute and decode stages.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package writeback_regfile_pkg;

    // CPSR flag bit positions and mode field.
    localparam int CPSR_N      = 31;
    localparam int CPSR_Z      = 30;
    localparam int CPSR_C      = 29;
    localparam int CPSR_V      = 28;
    localparam int CPSR_MODE_HI = 4;
    localparam int CPSR_MODE_LO = 0;

    // Register index constants.
    localparam logic [3:0] R_LR = 4'hE;
    localparam logic [3:0] R_PC = 4'hF;

    // SVC mode with IRQ and FIQ masked.
    localparam logic [31:0] DEFAULT_RESET_CPSR = 32'h000000D3;

    // Branch targets are word aligned; the low two bits of an r15 write are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/writeback_regfile_bank.sv
// 15x32 register storage (r0-r14), one write port, three asynchronous read ports.
// Latency: write visible on read ports the cycle after the write edge; reads are combinational.
// Backpressure: none; caller gates the write enable.
// Ports: clk/rst_n, we/waddr/wdata write port, raddr0..2 -> rdata0..2 read ports.
module regfile_bank
    import writeback_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr0,
    input  logic [3:0]  raddr1,
    input  logic [3:0]  raddr2,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] mem [0:14];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != R_PC)) begin
            mem[waddr] <= wdata;
        end
    end

    // r15 has no storage; the parent substitutes the PC value for that index.
    assign rdata0 = (raddr0 == R_PC) ? '0 : mem[raddr0];
    assign rdata1 = (raddr1 == R_PC) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == R_PC) ? '0 : mem[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits execute results to r0-r14/CPSR, r15 writes become a registered redirect.
// Latency: 1 cycle to architectural state; read ports are combinational with same-cycle bypass.
// Backpressure: stall freezes all state (including a pending redirect); the slot behind a redirect is squashed.
// Ports: clk/Nrst; stall, inbubble, write_reg/num/data, incpsr from execute; read_pc and rd_num0..2 from
//        decode with rd_data0..2 returned; cpsr architectural flags; jmp/jmppc redirect to fetch.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter logic [31:0] RESET_CPSR     = DEFAULT_RESET_CPSR,
    parameter logic [31:0] PC_READ_OFFSET = 32'h8
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        stall,
    input  logic        inbubble,
    input  logic        write_reg,
    input  logic [3:0]  write_num,
    input  logic [31:0] write_data,
    input  logic [31:0] incpsr,
    input  logic [31:0] read_pc,
    input  logic [3:0]  rd_num0,
    input  logic [3:0]  rd_num1,
    input  logic [3:0]  rd_num2,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic [31:0] cpsr,
    output logic        jmp,
    output logic [31:0] jmppc
);

    // While jmp is high the incoming slot is wrong-path and must not commit.
    logic        commit;
    logic        byp_vld;
    logic        bank_we;
    logic [31:0] pc_rd_dat;
    logic [31:0] bank_dat0, bank_dat1, bank_dat2;

    assign commit    = !stall && !inbubble && !jmp;
    assign byp_vld   = commit && write_reg;
    assign bank_we   = byp_vld && (write_num != R_PC);
    assign pc_rd_dat = read_pc + PC_READ_OFFSET;

    regfile_bank u_bank (
        .clk    (clk),
        .rst_n  (Nrst),
        .we     (bank_we),
        .waddr  (write_num),
        .wdata  (write_data),
        .raddr0 (rd_num0),
        .raddr1 (rd_num1),
        .raddr2 (rd_num2),
        .rdata0 (bank_dat0),
        .rdata1 (bank_dat1),
        .rdata2 (bank_dat2)
    );

    // r15 wins over bypass, so a same-cycle r15 write never shows up as PC read data.
    assign rd_data0 = (rd_num0 == R_PC) ? pc_rd_dat :
                      (byp_vld && (write_num == rd_num0)) ? write_data : bank_dat0;
    assign rd_data1 = (rd_num1 == R_PC) ? pc_rd_dat :
                      (byp_vld && (write_num == rd_num1)) ? write_data : bank_dat1;
    assign rd_data2 = (rd_num2 == R_PC) ? pc_rd_dat :
                      (byp_vld && (write_num == rd_num2)) ? write_data : bank_dat2;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            cpsr  <= RESET_CPSR;
            jmp   <= 1'b0;
            jmppc <= '0;
        end else if (!stall) begin
            if (jmp) begin
                // Redirect lasts exactly one unstalled cycle; jmppc keeps its last target.
                jmp <= 1'b0;
            end else if (!inbubble) begin
                cpsr <= incpsr;
                if (write_reg && (write_num == R_PC)) begin
                    jmp   <= 1'b1;
                    jmppc <= align_word(write_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        Nrst;
    logic        stall, inbubble, write_reg;
    logic [3:0]  write_num;
    logic [31:0] write_data, incpsr, read_pc;
    logic [3:0]  rd_num0, rd_num1, rd_num2;
    logic [31:0] rd_data0, rd_data1, rd_data2, cpsr, jmppc;
    logic        jmp;

    writeback_regfile dut (
        .clk(clk), .Nrst(Nrst), .stall(stall), .inbubble(inbubble),
        .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
        .incpsr(incpsr), .read_pc(read_pc),
        .rd_num0(rd_num0), .rd_num1(rd_num1), .rd_num2(rd_num2),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .cpsr(cpsr), .jmp(jmp), .jmppc(jmppc)
    );

    always #5 clk = ~clk;

    localparam int S_RD0 = 0, S_RD1 = 1, S_RD2 = 2, S_CPSR = 3, S_JMP = 4, S_JMPPC = 5;

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard: expectations queued at drive time, compared when the outputs are sampled.
    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];

    // Reference state.
    logic [31:0] m_reg [0:14];
    logic [31:0] m_cpsr, m_jmppc;
    logic        m_jmp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    task automatic drain();
        while (sel_q.size() > 0) begin
            string       t;
            int          s;
            logic [31:0] e, o;
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            case (s)
                S_RD0:   o = rd_data0;
                S_RD1:   o = rd_data1;
                S_RD2:   o = rd_data2;
                S_CPSR:  o = cpsr;
                S_JMP:   o = {31'd0, jmp};
                default: o = jmppc;
            endcase
            chk(t, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = '0;
        m_cpsr  = 32'h000000D3;
        m_jmp   = 1'b0;
        m_jmppc = '0;
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] num);
        logic commit_m;
        commit_m = !stall && !inbubble && !m_jmp;
        if (num == 4'hF) return read_pc + 32'h8;
        if (commit_m && write_reg && write_num == num) return write_data;
        return m_reg[num];
    endfunction

    task automatic model_edge();
        if (!stall) begin
            if (m_jmp) m_jmp = 1'b0;
            else if (!inbubble) begin
                m_cpsr = incpsr;
                if (write_reg) begin
                    if (write_num == 4'hF) begin
                        m_jmp   = 1'b1;
                        m_jmppc = {write_data[31:2], 2'b00};
                    end else begin
                        m_reg[write_num] = write_data;
                    end
                end
            end
        end
    endtask

    task automatic push_reads(input string tag);
        push({tag, "_rd0"}, S_RD0, exp_read(rd_num0));
        push({tag, "_rd1"}, S_RD1, exp_read(rd_num1));
        push({tag, "_rd2"}, S_RD2, exp_read(rd_num2));
    endtask

    task automatic push_state(input string tag);
        push({tag, "_cpsr"},  S_CPSR,  m_cpsr);
        push({tag, "_jmp"},   S_JMP,   {31'd0, m_jmp});
        push({tag, "_jmppc"}, S_JMPPC, m_jmppc);
    endtask

    // One clock with full model checking before and after the edge.
    task automatic step(input string tag);
        #1;
        push_reads({tag, "_pre"});
        drain();
        model_edge();
        @(posedge clk);
        #1;
        push_state(tag);
        push_reads({tag, "_post"});
        drain();
    endtask

    task automatic idle();
        stall = 1'b0; inbubble = 1'b1; write_reg = 1'b0;
    endtask

    task automatic slot(input logic [3:0] num, input logic [31:0] dat, input logic [31:0] ps);
        stall = 1'b0; inbubble = 1'b0; write_reg = 1'b1;
        write_num = num; write_data = dat; incpsr = ps;
    endtask

    // Read one register through port 2 with no commit in flight.
    task automatic peek(input string tag, input logic [3:0] num, input logic [31:0] exp);
        idle();
        rd_num2 = num;
        #1;
        push(tag, S_RD2, exp);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Nrst = 1'b0; stall = 1'b0; inbubble = 1'b1; write_reg = 1'b0;
        write_num = '0; write_data = '0; incpsr = 32'h000000D3; read_pc = 32'h100;
        rd_num0 = '0; rd_num1 = '0; rd_num2 = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 15; r++) begin
            rd_num0 = r[3:0]; rd_num1 = r[3:0]; rd_num2 = r[3:0];
            #1;
            push($sformatf("rst_r%0d_p0", r), S_RD0, 32'h0);
            push($sformatf("rst_r%0d_p1", r), S_RD1, 32'h0);
            push($sformatf("rst_r%0d_p2", r), S_RD2, 32'h0);
            drain();
        end
        rd_num0 = 4'hF;
        #1;
        push("rst_pc_read", S_RD0, 32'h108);
        push("rst_cpsr",    S_CPSR, 32'h000000D3);
        push("rst_jmp",     S_JMP,  32'h0);
        push("rst_jmppc",   S_JMPPC, 32'h0);
        drain();
        Nrst = 1'b1;

        // Commit and bypass to all three ports.
        slot(4'd3, 32'hDEADBEEF, 32'h600000D3);
        rd_num0 = 4'd3; rd_num1 = 4'd3; rd_num2 = 4'd3;
        #1;
        push("byp_rd1_pre", S_RD1, 32'hDEADBEEF);
        push("byp_rd0_pre", S_RD0, 32'hDEADBEEF);
        drain();
        step("commit");
        push("byp_rd1_post", S_RD1, 32'hDEADBEEF);
        push("commit_cpsr",  S_CPSR, 32'h600000D3);
        drain();
        peek("r3_stored", 4'd3, 32'hDEADBEEF);

        // Bubble suppresses commit.
        slot(4'd4, 32'd5, 32'h100000D3);
        inbubble = 1'b1;
        step("bubble");
        peek("bubble_r4", 4'd4, 32'h0);

        // Stall suppresses commit and bypass.
        slot(4'd4, 32'd7, 32'hF00000D3);
        stall = 1'b1;
        rd_num0 = 4'd4; rd_num1 = 4'd4;
        step("stall");
        push("stall_cpsr", S_CPSR, 32'h600000D3);
        drain();
        peek("stall_r4", 4'd4, 32'h0);
        slot(4'd4, 32'd7, 32'hF00000D3);
        step("unstall");
        peek("unstall_r4", 4'd4, 32'd7);

        // Branch via r15, wrong-path slot squashed.
        slot(4'hF, 32'h00002003, 32'h600000D3);
        rd_num0 = 4'hF; read_pc = 32'hFFFF_FFFC;
        step("br");
        push("br_jmp",   S_JMP,   32'h1);
        push("br_jmppc", S_JMPPC, 32'h2000);
        push("pc_wrap",  S_RD0,   32'h4);
        drain();
        slot(4'd5, 32'd9, 32'h000000D3);
        rd_num1 = 4'd5;
        step("squash");
        push("squash_jmp", S_JMP, 32'h0);
        drain();
        peek("squash_r5", 4'd5, 32'h0);

        // Redirect held across a stall.
        slot(4'hF, 32'h00003005, 32'h200000D3);
        step("br2");
        slot(4'd6, 32'd1, 32'h800000D3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i));
            push($sformatf("hold%0d_jmp", i),   S_JMP,   32'h1);
            push($sformatf("hold%0d_jmppc", i), S_JMPPC, 32'h3004);
            drain();
        end
        stall = 1'b0;
        step("release");
        push("release_jmp", S_JMP, 32'h0);
        drain();
        peek("release_r6", 4'd6, 32'h0);
        slot(4'd6, 32'h66, 32'h400000D3);
        step("after_br");
        peek("after_br_r6", 4'd6, 32'h66);

        // Asynchronous reset while a redirect is pending.
        slot(4'hF, 32'h00004000, 32'h000000D3);
        step("br3");
        push("br3_jmp", S_JMP, 32'h1);
        drain();
        #2 Nrst = 1'b0;
        #1;
        model_reset();
        push("arst_jmp",   S_JMP,   32'h0);
        push("arst_cpsr",  S_CPSR,  32'h000000D3);
        push("arst_jmppc", S_JMPPC, 32'h0);
        drain();
        #1 Nrst = 1'b1;
        peek("arst_r6", 4'd6, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            stall      = ($urandom_range(0, 5) == 0);
            inbubble   = ($urandom_range(0, 4) == 0);
            write_reg  = ($urandom_range(0, 3) != 0);
            write_num  = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            write_data = $urandom;
            incpsr     = $urandom;
            read_pc    = $urandom;
            rd_num0    = 4'($urandom_range(0, 15));
            rd_num1    = ($urandom_range(0, 2) == 0) ? write_num : 4'($urandom_range(0, 15));
            rd_num2    = 4'($urandom_range(0, 15));
            step($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
